// File: rtl/dm_access_ctrl.sv
// MEM-stage load/store sequencer for a req/ack data memory, with wait timeout.
// Optional: define DM_ALIGN_CHECK_EN to trap misaligned halfword/word accesses.
module dm_access_ctrl #(
   parameter int unsigned WAIT_MAX = 16,
   parameter int unsigned CNT_W    = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_valid,
   input  logic [5:0]  op,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic [31:0] rdata_out,
   output logic        rdata_valid,
   output logic        bus_err,
   output logic        adel,
   output logic        ades,
   output logic        dm_req,
   output logic        dm_we,
   output logic [3:0]  dm_be,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   input  logic        dm_ack,
   input  logic [31:0] dm_rdata
);

   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_LBU = 6'b100100;
   localparam logic [5:0] OP_LHU = 6'b100101;
   localparam logic [5:0] OP_SB  = 6'b101000;
   localparam logic [5:0] OP_SH  = 6'b101001;
   localparam logic [5:0] OP_SW  = 6'b101011;

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       op_q;      // {unsigned, size[1:0]} of the latched access
   logic [1:0]       sel_q;
   logic             we_q;

   logic             mem_op, is_load, misaligned, timeout;
   logic [3:0]       be_nxt;
   logic [31:0]      wdata_nxt, rdata_ext;
   logic [7:0]       rd_byte;
   logic [15:0]      rd_half;

   assign mem_op  = mem_valid && (op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
                                             OP_SB, OP_SH, OP_SW});
   assign is_load = ~op[3];
   assign timeout = (cnt == CNT_W'(WAIT_MAX - 1));

`ifdef DM_ALIGN_CHECK_EN
   assign misaligned = ((op[1:0] == 2'b01) && addr[0]) ||
                       ((op[1:0] == 2'b11) && (addr[1:0] != 2'b00));
`else
   assign misaligned = 1'b0;
`endif

   // NOTE: every signal gets a default before the case so no latch is inferred.
   always_comb begin
      be_nxt    = 4'b1111;
      wdata_nxt = wdata;
      if (!is_load) begin
         case (op[1:0])
            2'b00: begin
               be_nxt    = 4'b0001 << addr[1:0];
               wdata_nxt = {4{wdata[7:0]}};
            end
            2'b01: begin
               be_nxt    = addr[1] ? 4'b1100 : 4'b0011;
               wdata_nxt = {2{wdata[15:0]}};
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      rd_byte = dm_rdata[{sel_q, 3'b000} +: 8];
      rd_half = sel_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
      case (op_q[1:0])
         2'b00:   rdata_ext = op_q[2] ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
         2'b01:   rdata_ext = op_q[2] ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
         default: rdata_ext = dm_rdata;
      endcase
   end

   // Stall is combinational so the pipeline freezes in the cycle the access is seen.
   always_comb begin
      state_nxt = state;
      stall     = 1'b0;
      dm_req    = 1'b0;
      case (state)
         IDLE: begin
            if (mem_op && !reset) begin
               stall     = 1'b1;
               state_nxt = misaligned ? DONE : REQ;
            end
         end
         REQ: begin
            stall  = 1'b1;
            dm_req = 1'b1;
            if (dm_ack || timeout) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign dm_we = we_q & dm_req;

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         op_q        <= '0;
         sel_q       <= '0;
         we_q        <= 1'b0;
         dm_be       <= '0;
         dm_addr     <= '0;
         dm_wdata    <= '0;
         rdata_out   <= '0;
         rdata_valid <= 1'b0;
         bus_err     <= 1'b0;
         adel        <= 1'b0;
         ades        <= 1'b0;
      end else begin
         state       <= state_nxt;
         rdata_valid <= 1'b0;
         bus_err     <= 1'b0;
         adel        <= 1'b0;
         ades        <= 1'b0;
         case (state)
            IDLE: begin
               if (mem_op) begin
                  op_q     <= op[2:0];
                  sel_q    <= addr[1:0];
                  we_q     <= ~is_load;
                  dm_addr  <= {addr[31:2], 2'b00};
                  dm_be    <= be_nxt;
                  dm_wdata <= wdata_nxt;
                  cnt      <= '0;
                  adel     <= misaligned & is_load;
                  ades     <= misaligned & ~is_load;
               end
            end
            REQ: begin
               if (dm_ack) begin
                  if (!we_q) begin
                     rdata_out   <= rdata_ext;
                     rdata_valid <= 1'b1;
                  end
               end else if (timeout) begin
                  rdata_out <= '0;
                  bus_err   <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE:    cnt <= '0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Scoreboard bench for dm_access_ctrl: random loads/stores against a byte-lane memory model.
module tb_dm_access_ctrl;

   localparam int WAIT_MAX = 4;

   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_LBU = 6'b100100;
   localparam logic [5:0] OP_LHU = 6'b100101;
   localparam logic [5:0] OP_SB  = 6'b101000;
   localparam logic [5:0] OP_SH  = 6'b101001;
   localparam logic [5:0] OP_SW  = 6'b101011;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_valid;
   logic [5:0]  op;
   logic [31:0] addr, wdata;
   logic        stall;
   logic [31:0] rdata_out;
   logic        rdata_valid, bus_err, adel, ades;
   logic        dm_req, dm_we;
   logic [3:0]  dm_be;
   logic [31:0] dm_addr, dm_wdata;
   logic        dm_ack;
   logic [31:0] dm_rdata;

   always #5 clk = ~clk;

   dm_access_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .mem_valid(mem_valid), .op(op), .addr(addr),
      .wdata(wdata), .stall(stall), .rdata_out(rdata_out), .rdata_valid(rdata_valid),
      .bus_err(bus_err), .adel(adel), .ades(ades), .dm_req(dm_req), .dm_we(dm_we),
      .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ack(dm_ack),
      .dm_rdata(dm_rdata)
   );

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          delay;
      int          exp_cycles;
   } req_t;

   typedef struct {
      logic [3:0]  flags;   // {rdata_valid, bus_err, adel, ades}
      logic [31:0] rdata;
   } cpl_t;

   req_t        req_q[$];
   cpl_t        cpl_q[$];
   int          n_cmp = 0;
   int          n_fail = 0;
   bit          aborted = 1'b0;
   logic [31:0] model_rdata = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Memory responder: acks after the planned number of wait cycles, checks request fields.
   initial begin : responder
      req_t cur;
      bit   in_req;
      bit   bogus;
      int   wcnt;
      in_req   = 1'b0;
      bogus    = 1'b0;
      wcnt     = 0;
      dm_ack   = 1'b0;
      dm_rdata = '0;
      forever begin
         @(negedge clk);
         if (dm_req === 1'b1) begin
            if (!in_req) begin
               in_req = 1'b1;
               wcnt   = 0;
               bogus  = 1'b0;
               if (req_q.size() == 0) begin
                  n_cmp++;
                  n_fail++;
                  $display("FAIL unexpected_req: dm_req=1 expected 0");
                  bogus          = 1'b1;
                  cur.delay      = 0;
                  cur.exp_cycles = 1;
                  cur.rdata      = '0;
               end else begin
                  cur = req_q.pop_front();
               end
            end
            if (!bogus) begin
               check("dm_addr", dm_addr, cur.addr);
               check("dm_we", {31'b0, dm_we}, {31'b0, cur.we});
               check("dm_be", {28'b0, dm_be}, {28'b0, cur.be});
               if (cur.we) check("dm_wdata", dm_wdata, cur.wdata);
            end
            dm_ack   = (wcnt == cur.delay);
            dm_rdata = dm_ack ? cur.rdata : $urandom();
            wcnt++;
         end else begin
            if (in_req) begin
               if (!aborted && !bogus) check("req_cycles", wcnt, cur.exp_cycles);
               aborted = 1'b0;
            end
            in_req = 1'b0;
            dm_ack = 1'b0;
         end
      end
   end

   // Completion monitor: any status pulse must match the oldest expected completion.
   initial begin : monitor
      cpl_t e;
      forever begin
         @(negedge clk);
         if (reset !== 1'b1 && (rdata_valid | bus_err | adel | ades)) begin
            if (cpl_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_cpl: flags=%b expected none",
                        {rdata_valid, bus_err, adel, ades});
            end else begin
               e = cpl_q.pop_front();
               check("cpl_flags", {28'b0, rdata_valid, bus_err, adel, ades}, {28'b0, e.flags});
               check("cpl_rdata", rdata_out, e.rdata);
            end
         end
      end
   end

   // Reference model: describes each opcode by size/sign/direction and derives the bus view.
   task automatic run_instr(input logic v, input logic [5:0] o, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] rw, input int dly);
      int          size, s, off, exp_stall, stall_n;
      bit          sgn, ld, is_mem, mis;
      logic [31:0] mask, val;
      req_t        r;
      cpl_t        c;
      is_mem = v;
      size   = 4;
      sgn    = 1'b0;
      ld     = 1'b1;
      case (o)
         OP_LB:   begin size = 1; sgn = 1'b1; end
         OP_LH:   begin size = 2; sgn = 1'b1; end
         OP_LW:   size = 4;
         OP_LBU:  size = 1;
         OP_LHU:  size = 2;
         OP_SB:   begin size = 1; ld = 1'b0; end
         OP_SH:   begin size = 2; ld = 1'b0; end
         OP_SW:   ld = 1'b0;
         default: is_mem = 1'b0;
      endcase
      s   = int'(a[1:0]);
      mis = 1'b0;
`ifdef DM_ALIGN_CHECK_EN
      mis = (s % size) != 0;
`endif
      mask = (size == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * size)) - 32'h1;
      off  = (s / size) * size;
      val  = (rw >> (8 * off)) & mask;
      if (sgn && val[8 * size - 1]) val = val | ~mask;
      r.addr       = a & 32'hFFFF_FFFC;
      r.we         = !ld;
      r.be         = ld ? 4'hF : (size == 1) ? 4'(1 << s) : (size == 2) ? 4'(3 << off) : 4'hF;
      r.wdata      = (size == 1) ? (wd & 32'hFF) * 32'h0101_0101 :
                     (size == 2) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
      r.rdata      = rw;
      r.delay      = dly;
      r.exp_cycles = (dly < WAIT_MAX) ? dly + 1 : WAIT_MAX;
      exp_stall    = 0;

      @(posedge clk);
      #1;
      mem_valid = v;
      op        = o;
      addr      = a;
      wdata     = wd;
      if (is_mem) begin
         exp_stall = 1;
         if (mis) begin
            c.flags = ld ? 4'b0010 : 4'b0001;
            c.rdata = model_rdata;
            cpl_q.push_back(c);
         end else begin
            req_q.push_back(r);
            exp_stall += r.exp_cycles;
            if (dly >= WAIT_MAX) begin
               model_rdata = '0;
               c.flags     = 4'b0100;
               c.rdata     = '0;
               cpl_q.push_back(c);
            end else if (ld) begin
               model_rdata = val;
               c.flags     = 4'b1000;
               c.rdata     = val;
               cpl_q.push_back(c);
            end
         end
      end

      stall_n = 0;
      for (int k = 0; k < 64; k++) begin
         @(negedge clk);
         if (stall) stall_n++;
         else break;
      end
      check("stall_cycles", stall_n, exp_stall);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      logic [5:0] ops [10];
      ops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW, 6'h00, 6'h2c};

      reset     = 1'b1;
      mem_valid = 1'b0;
      op        = '0;
      addr      = '0;
      wdata     = '0;
      repeat (2) @(negedge clk);
      check("rst_dm_req", {31'b0, dm_req}, 32'h0);
      check("rst_dm_we", {31'b0, dm_we}, 32'h0);
      check("rst_dm_be", {28'b0, dm_be}, 32'h0);
      check("rst_dm_addr", dm_addr, 32'h0);
      check("rst_dm_wdata", dm_wdata, 32'h0);
      check("rst_rdata_out", rdata_out, 32'h0);
      check("rst_pulses", {28'b0, rdata_valid, bus_err, adel, ades}, 32'h0);
      check("rst_stall", {31'b0, stall}, 32'h0);
      reset = 1'b0;

      run_instr(1'b1, OP_LB, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0);
      check("lb_rdata", rdata_out, 32'hFFFF_FF80);
      run_instr(1'b1, OP_SH, 32'h0000_2002, 32'hDEAD_BEEF, 32'h0, 3);
      run_instr(1'b1, OP_LHU, 32'h0000_0002, 32'h0, 32'h9ABC_0000, 0);
      check("lhu_rdata", rdata_out, 32'h0000_9ABC);
      run_instr(1'b1, OP_LW, 32'h0000_0010, 32'h0, 32'h1234_5678, 0);
      check("lw_rdata", rdata_out, 32'h1234_5678);
      run_instr(1'b1, OP_SW, 32'h0000_3000, 32'hA5A5_5A5A, 32'h0, 1000);
      check("to_bus_err", {31'b0, bus_err}, 32'h1);
      check("to_rdata", rdata_out, 32'h0);

      // Reset in the middle of a request: the access is abandoned.
      @(posedge clk);
      #1;
      req_q.push_back('{addr: 32'h40, we: 1'b0, be: 4'hF, wdata: 32'h0,
                        rdata: 32'h0, delay: 1000, exp_cycles: 0});
      mem_valid = 1'b1;
      op        = OP_LW;
      addr      = 32'h0000_0040;
      @(negedge clk);
      @(negedge clk);
      check("mid_dm_req", {31'b0, dm_req}, 32'h1);
      #2;
      aborted = 1'b1;
      reset   = 1'b1;
      #1;
      check("rst_drop_req", {31'b0, dm_req}, 32'h0);
      check("rst_drop_stall", {31'b0, stall}, 32'h0);
      mem_valid   = 1'b0;
      model_rdata = '0;
      repeat (2) @(negedge clk);
      check("rst_rdata_valid", {31'b0, rdata_valid}, 32'h0);
      reset = 1'b0;
      run_instr(1'b1, OP_LW, 32'h0000_0044, 32'h0, 32'h0BAD_F00D, 1);
      check("post_rst_lw", rdata_out, 32'h0BAD_F00D);

      run_instr(1'b1, OP_LW, 32'h0000_0006, 32'h0, 32'hCAFE_F00D, 0);
`ifdef DM_ALIGN_CHECK_EN
      check("mis_adel", {31'b0, adel}, 32'h1);
      check("mis_ades", {31'b0, ades}, 32'h0);
`else
      check("mis_trunc", rdata_out, 32'hCAFE_F00D);
`endif

      for (int i = 0; i < 150; i++) begin
         run_instr($urandom_range(0, 7) != 0, ops[$urandom_range(0, 9)], $urandom(),
                   $urandom(), $urandom(), int'($urandom_range(0, 5)));
      end

      @(posedge clk);
      #1;
      mem_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("pending_cpl", cpl_q.size(), 32'h0);
      check("pending_req", req_q.size(), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
